// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter and its picker.
//   arb_state_t : arbiter FSM encoding (IDLE = no owner, BUSY = owner granted)
//   WB_DW/WB_SW : Wishbone data width and byte-select width
//   NM_MAX      : largest supported master count
//   wdog_width(): watchdog counter width, at least 8 bits and wide enough for TIMEOUT
package wb_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int WB_DW  = 32;
  localparam int WB_SW  = 4;
  localparam int NM_MAX = 8;

  function automatic int wdog_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
// Scans i_last_idx+1, i_last_idx+2, ... (wrapping modulo NM) and returns the
// first requester found.
//   i_req      : per-requester request bits
//   i_last_idx : index of the most recently served requester
//   o_valid    : at least one request present
//   o_idx      : chosen requester (0 when o_valid is low)
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NM = 4,
  localparam int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [IW-1:0] i_last_idx,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  int w_cand;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = 1; k <= NM; k++) begin
      // explicit wrap so non-power-of-2 NM never indexes past the last requester
      w_cand = int'(i_last_idx) + k;
      if (w_cand >= NM) w_cand = w_cand - NM;
      if (!o_valid && i_req[w_cand[IW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between NM masters.
// Ownership lasts for a whole CYC, so block and RMW cycles are never split.
// A watchdog terminates a strobe that waits TIMEOUT cycles with ERR to the owner.
//
// state | meaning
// IDLE  | no owner; slave control lines low; arbitration happens this cycle
// BUSY  | master r_gnt_idx owns the slave; its lines are forwarded
//
// Ports:
//   CLK_I, RST_I                 : clock, asynchronous active-high reset
//   M_CYC/STB/WE_I               : per-master control, one bit each
//   M_ADR_I/M_DAT_I/M_SEL_I      : per-master address/data/select, packed
//   M_ACK/ERR/RTY_O              : per-master terminations (owner only)
//   M_DAT_O                      : read data broadcast to all masters
//   S_*_O / S_*_I                : single slave port
//   GNT_O                        : one-hot current owner
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM      = 4,
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [NM-1:0]       M_CYC_I,
  input  logic [NM-1:0]       M_STB_I,
  input  logic [NM-1:0]       M_WE_I,
  input  logic [NM*AW-1:0]    M_ADR_I,
  input  logic [NM*WB_DW-1:0] M_DAT_I,
  input  logic [NM*WB_SW-1:0] M_SEL_I,
  output logic [NM-1:0]       M_ACK_O,
  output logic [NM-1:0]       M_ERR_O,
  output logic [NM-1:0]       M_RTY_O,
  output logic [WB_DW-1:0]    M_DAT_O,
  output logic                S_CYC_O,
  output logic                S_STB_O,
  output logic                S_WE_O,
  output logic [AW-1:0]       S_ADR_O,
  output logic [WB_DW-1:0]    S_DAT_O,
  output logic [WB_SW-1:0]    S_SEL_O,
  input  logic                S_ACK_I,
  input  logic                S_ERR_I,
  input  logic                S_RTY_I,
  input  logic [WB_DW-1:0]    S_DAT_I,
  output logic [NM-1:0]       GNT_O
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int WW = wdog_width(TIMEOUT);

  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_gnt_idx, w_gnt_nxt;
  logic [IW-1:0] r_last_idx, w_last_nxt;
  logic [WW-1:0] r_wdog, w_wdog_nxt;

  logic          w_pick_valid;
  logic [IW-1:0] w_pick_idx;
  logic          w_busy, w_term, w_wd_fire;
  logic          w_cyc, w_stb, w_we;
  logic [AW-1:0] w_adr;
  logic [WB_DW-1:0] w_dat;
  logic [WB_SW-1:0] w_sel;

  wb_rr_pick #(.NM(NM)) u_pick (
    .i_req      (M_CYC_I),
    .i_last_idx (r_last_idx),
    .o_valid    (w_pick_valid),
    .o_idx      (w_pick_idx)
  );

  // Owner mux; data/address follow r_gnt_idx even in IDLE so they hold the
  // last owner's values after release.
  always_comb begin
    w_cyc = 1'b0;
    w_stb = 1'b0;
    w_we  = 1'b0;
    w_adr = M_ADR_I[AW-1:0];
    w_dat = M_DAT_I[WB_DW-1:0];
    w_sel = M_SEL_I[WB_SW-1:0];
    for (int i = 0; i < NM; i++) begin
      if (r_gnt_idx == IW'(i)) begin
        w_cyc = M_CYC_I[i];
        w_stb = M_STB_I[i];
        w_we  = M_WE_I[i];
        w_adr = M_ADR_I[i*AW +: AW];
        w_dat = M_DAT_I[i*WB_DW +: WB_DW];
        w_sel = M_SEL_I[i*WB_SW +: WB_SW];
      end
    end
  end

  assign w_busy = (r_state == ST_BUSY);
  assign w_term = S_ACK_I | S_ERR_I | S_RTY_I;

  // a slave termination in the firing cycle takes precedence over the watchdog
  assign w_wd_fire = (TIMEOUT != 0) && w_busy && w_stb && !w_term &&
                     (r_wdog == WW'(TIMEOUT));

  assign S_CYC_O = w_busy & w_cyc;
  assign S_STB_O = w_busy & w_stb & ~w_wd_fire;
  assign S_WE_O  = w_we;
  assign S_ADR_O = w_adr;
  assign S_DAT_O = w_dat;
  assign S_SEL_O = w_sel;
  assign M_DAT_O = S_DAT_I;

  always_comb begin
    M_ACK_O = '0;
    M_ERR_O = '0;
    M_RTY_O = '0;
    GNT_O   = '0;
    for (int i = 0; i < NM; i++) begin
      if (w_busy && (r_gnt_idx == IW'(i))) begin
        GNT_O[i]   = 1'b1;
        M_ACK_O[i] = S_ACK_I;
        M_ERR_O[i] = S_ERR_I | w_wd_fire;
        M_RTY_O[i] = S_RTY_I;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_idx;
    w_last_nxt  = r_last_idx;
    w_wdog_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = w_pick_idx;
        end
      end
      ST_BUSY: begin
        if (!w_cyc) begin
          // the releasing master becomes lowest priority for the next pick
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_gnt_idx;
        end else if ((TIMEOUT != 0) && S_STB_O && !w_term) begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state    <= ST_IDLE;
      r_gnt_idx  <= '0;
      r_last_idx <= IW'(NM - 1);
      r_wdog     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_idx  <= w_gnt_nxt;
      r_last_idx <= w_last_nxt;
      r_wdog     <= w_wdog_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (NM=4, AW=8, TIMEOUT=8): single write,
// full rotation, block write with a competing master, watchdog timeout and
// asynchronous reset mid-transfer.
module tb_wb_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 8;

  logic            CLK_I = 1'b0;
  logic            RST_I;
  logic [NM-1:0]   m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*32-1:0] m_dat;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]   M_ACK_O, M_ERR_O, M_RTY_O, GNT_O;
  logic [31:0]     M_DAT_O;
  logic            S_CYC_O, S_STB_O, S_WE_O;
  logic [AW-1:0]   S_ADR_O;
  logic [31:0]     S_DAT_O;
  logic [3:0]      S_SEL_O;
  logic            S_ACK_I, S_ERR_I, S_RTY_I;
  logic [31:0]     S_DAT_I;

  int errors = 0;
  int checks = 0;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .TIMEOUT(8)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .M_CYC_I (m_cyc),
    .M_STB_I (m_stb),
    .M_WE_I  (m_we),
    .M_ADR_I (m_adr),
    .M_DAT_I (m_dat),
    .M_SEL_I (m_sel),
    .M_ACK_O (M_ACK_O),
    .M_ERR_O (M_ERR_O),
    .M_RTY_O (M_RTY_O),
    .M_DAT_O (M_DAT_O),
    .S_CYC_O (S_CYC_O),
    .S_STB_O (S_STB_O),
    .S_WE_O  (S_WE_O),
    .S_ADR_O (S_ADR_O),
    .S_DAT_O (S_DAT_O),
    .S_SEL_O (S_SEL_O),
    .S_ACK_I (S_ACK_I),
    .S_ERR_I (S_ERR_I),
    .S_RTY_I (S_RTY_I),
    .S_DAT_I (S_DAT_I),
    .GNT_O   (GNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int e;

  initial begin
    RST_I = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    S_ACK_I = 1'b0; S_ERR_I = 1'b0; S_RTY_I = 1'b0; S_DAT_I = '0;

    // reset state
    tick(); tick();
    chk("rst_cyc", 32'(S_CYC_O), 32'd0);
    chk("rst_stb", 32'(S_STB_O), 32'd0);
    chk("rst_gnt", 32'(GNT_O), 32'd0);
    chk("rst_ack", 32'(M_ACK_O), 32'd0);
    RST_I = 1'b0;

    // single write from master 0
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[7:0] = 8'h04; m_dat[31:0] = 32'hA5A5_0001; m_sel[3:0] = 4'hF;
    settle();
    chk("w1_idle_cyc", 32'(S_CYC_O), 32'd0);
    tick();
    chk("w1_cyc", 32'(S_CYC_O), 32'd1);
    chk("w1_stb", 32'(S_STB_O), 32'd1);
    chk("w1_we", 32'(S_WE_O), 32'd1);
    chk("w1_adr", 32'(S_ADR_O), 32'h04);
    chk("w1_dat", S_DAT_O, 32'hA5A5_0001);
    chk("w1_sel", 32'(S_SEL_O), 32'hF);
    chk("w1_gnt", 32'(GNT_O), 32'b0001);
    S_ACK_I = 1'b1;
    settle();
    chk("w1_ack", 32'(M_ACK_O), 32'b0001);
    chk("w1_rty", 32'(M_RTY_O), 32'd0);
    tick();
    S_ACK_I = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    settle();
    chk("w1_drop_cyc", 32'(S_CYC_O), 32'd0);
    tick();
    chk("w1_idle_gnt", 32'(GNT_O), 32'd0);

    // rotation after a fresh reset: 0,1,2,3,0 with a dead cycle between owners
    RST_I = 1'b1; settle(); RST_I = 1'b0;
    m_cyc = 4'b1111; m_stb = 4'b1111; m_we = 4'b0000;
    for (int i = 0; i < NM; i++) m_adr[i*AW +: AW] = 8'h10 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      tick();
      chk("rr_gnt", 32'(GNT_O), 32'd1 << e);
      chk("rr_adr", 32'(S_ADR_O), 32'h10 + 32'(e));
      tick();
      S_ACK_I = 1'b1; S_DAT_I = 32'hD000_0000 + 32'(e);
      settle();
      chk("rr_ack", 32'(M_ACK_O), 32'd1 << e);
      chk("rr_rdat", M_DAT_O, 32'hD000_0000 + 32'(e));
      tick();
      S_ACK_I = 1'b0; m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
      if (k == 4) begin m_cyc = '0; m_stb = '0; end
      settle();
      chk("rr_drop_cyc", 32'(S_CYC_O), 32'd0);
      tick();
      chk("rr_dead_gnt", 32'(GNT_O), 32'd0);
      chk("rr_dead_cyc", 32'(S_CYC_O), 32'd0);
      if (k < 4) begin m_cyc[e] = 1'b1; m_stb[e] = 1'b1; end
    end

    // master 2 block write, master 1 waiting
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1; m_sel[11:8] = 4'h3;
    m_adr[23:16] = 8'h20; m_dat[95:64] = 32'hB000_0000;
    tick();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[15:8] = 8'h11;
    for (int b = 0; b < 4; b++) begin
      m_adr[23:16] = 8'h20 + 8'(b);
      m_dat[95:64] = 32'hB000_0000 + 32'(b);
      S_ACK_I = 1'b1;
      settle();
      chk("blk_adr", 32'(S_ADR_O), 32'h20 + 32'(b));
      chk("blk_dat", S_DAT_O, 32'hB000_0000 + 32'(b));
      chk("blk_ack", 32'(M_ACK_O), 32'b0100);
      chk("blk_gnt", 32'(GNT_O), 32'b0100);
      tick();
    end
    S_ACK_I = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    settle();
    chk("blk_rel_ack", 32'(M_ACK_O), 32'd0);
    chk("blk_rel_gnt", 32'(GNT_O), 32'b0100);
    tick();
    chk("blk_dead_gnt", 32'(GNT_O), 32'd0);
    chk("blk_dead_cyc", 32'(S_CYC_O), 32'd0);
    tick();
    chk("blk_m1_gnt", 32'(GNT_O), 32'b0010);
    chk("blk_m1_adr", 32'(S_ADR_O), 32'h11);
    chk("blk_m1_we", 32'(S_WE_O), 32'd0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    tick();

    // watchdog: master 3 strobes, slave never answers
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_we[3] = 1'b0; m_adr[31:24] = 8'h33;
    tick();
    for (int n = 1; n <= 8; n++) begin
      chk("wd_wait_stb", 32'(S_STB_O), 32'd1);
      chk("wd_wait_err", 32'(M_ERR_O), 32'd0);
      tick();
    end
    chk("wd_fire_err", 32'(M_ERR_O), 32'b1000);
    chk("wd_fire_stb", 32'(S_STB_O), 32'd0);
    chk("wd_fire_ack", 32'(M_ACK_O), 32'd0);
    tick();
    chk("wd_after_err", 32'(M_ERR_O), 32'd0);
    chk("wd_after_stb", 32'(S_STB_O), 32'd1);
    repeat (8) tick();
    S_ACK_I = 1'b1;
    settle();
    chk("wd_race_ack", 32'(M_ACK_O), 32'b1000);
    chk("wd_race_err", 32'(M_ERR_O), 32'd0);
    chk("wd_race_stb", 32'(S_STB_O), 32'd1);
    tick();
    S_ACK_I = 1'b0; m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
    settle();
    chk("wd_rel_cyc", 32'(S_CYC_O), 32'd0);
    tick();
    chk("wd_idle_gnt", 32'(GNT_O), 32'd0);

    // async reset mid-BUSY; last_idx must return to NM-1
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    chk("ar_m1_gnt", 32'(GNT_O), 32'b0010);
    m_cyc = 4'b0000; m_stb = 4'b0000;
    tick();
    m_cyc = 4'b1111; m_stb = 4'b1111;
    tick();
    chk("ar_m2_gnt", 32'(GNT_O), 32'b0100);
    settle();
    RST_I = 1'b1;
    settle();
    chk("ar_cyc", 32'(S_CYC_O), 32'd0);
    chk("ar_stb", 32'(S_STB_O), 32'd0);
    chk("ar_gnt", 32'(GNT_O), 32'd0);
    tick();
    RST_I = 1'b0;
    tick();
    chk("ar_first_gnt", 32'(GNT_O), 32'b0001);
    chk("ar_first_cyc", 32'(S_CYC_O), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
